// File: rtl/mag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mag_pkg
// Brief    : Shared port-ID encoding and estimator latency for mag_arbiter.
// Revision : 1.0
// ============================================================================
package mag_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam int c_EST_LATENCY = 3;

endpackage
`default_nettype wire

// File: rtl/complex_to_mag.sv
`default_nettype none
// ============================================================================
// Module   : complex_to_mag
// Brief    : 3-stage alpha-max-plus-beta-min magnitude (alpha=1, beta=1/4).
// Revision : 1.0
// ============================================================================
module complex_to_mag #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] input_i,
    input  logic signed [DATA_WIDTH-1:0] input_q,
    input  logic                         input_strobe,
    output logic        [DATA_WIDTH-1:0] mag,
    output logic                         mag_stb
);

    logic [DATA_WIDTH-1:0] w_abs_i;
    logic [DATA_WIDTH-1:0] w_abs_q;
    logic [DATA_WIDTH-1:0] r_abs_i;
    logic [DATA_WIDTH-1:0] r_abs_q;
    logic [DATA_WIDTH-1:0] r_max;
    logic [DATA_WIDTH-1:0] r_min_q;
    logic [DATA_WIDTH-1:0] r_mag;
    logic                  r_v1;
    logic                  r_v2;
    logic                  r_v3;

    // Two's-complement negate in DATA_WIDTH bits: the most negative value maps
    // to its unsigned magnitude 2^(DATA_WIDTH-1) without saturating.
    assign w_abs_i = input_i[DATA_WIDTH-1] ? (~input_i + 1'b1) : input_i;
    assign w_abs_q = input_q[DATA_WIDTH-1] ? (~input_q + 1'b1) : input_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_abs_i <= '0;
            r_abs_q <= '0;
            r_max   <= '0;
            r_min_q <= '0;
            r_mag   <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
        end else if (enable) begin
            r_abs_i <= w_abs_i;
            r_abs_q <= w_abs_q;
            r_v1    <= input_strobe;
            r_max   <= (r_abs_i > r_abs_q) ? r_abs_i : r_abs_q;
            r_min_q <= ((r_abs_i > r_abs_q) ? r_abs_q : r_abs_i) >> 2;
            r_v2    <= r_v1;
            r_mag   <= r_max + r_min_q;
            r_v3    <= r_v2;
        end
    end

    assign mag     = r_mag;
    assign mag_stb = r_v3;

endmodule
`default_nettype wire

// File: rtl/mag_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mag_arbiter
// Brief    : Round-robin sharing of one magnitude estimator by two ports.
// Revision : 1.0
// ============================================================================
module mag_arbiter
    import mag_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] a_q,
    input  logic                         a_stb,
    output logic                         a_ready,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    input  logic signed [DATA_WIDTH-1:0] b_q,
    input  logic                         b_stb,
    output logic                         b_ready,
    output logic        [DATA_WIDTH-1:0] a_mag,
    output logic        [DATA_WIDTH-1:0] b_mag,
    output logic                         a_mag_stb,
    output logic                         b_mag_stb,
    output logic                         a_drop,
    output logic                         b_drop,
    output logic        [7:0]            a_drop_cnt,
    output logic        [7:0]            b_drop_cnt
);

    logic [1:0]                   w_stb;
    logic [1:0]                   w_ready;
    logic [1:0]                   w_grant;
    logic [1:0]                   w_valid;
    logic [1:0]                   w_drop;
    logic signed [DATA_WIDTH-1:0] w_in_i   [2];
    logic signed [DATA_WIDTH-1:0] w_in_q   [2];
    logic signed [DATA_WIDTH-1:0] w_buf_i  [2];
    logic signed [DATA_WIDTH-1:0] w_buf_q  [2];
    logic [7:0]                   w_drop_cnt [2];
    logic signed [DATA_WIDTH-1:0] w_est_i;
    logic signed [DATA_WIDTH-1:0] w_est_q;
    logic                         w_est_stb;
    logic [DATA_WIDTH-1:0]        w_mag;
    port_e                        r_last;
    port_e                        r_tag_p [c_EST_LATENCY];
    logic [c_EST_LATENCY-1:0]     r_tag_v;

    assign w_stb     = {b_stb, a_stb};
    assign w_in_i[0] = a_i;
    assign w_in_q[0] = a_q;
    assign w_in_i[1] = b_i;
    assign w_in_q[1] = b_q;

    // Round robin: on a tie the port not granted last time wins.
    assign w_grant[0] = w_valid[0] & (~w_valid[1] | (r_last == PORT_B));
    assign w_grant[1] = w_valid[1] & (~w_valid[0] | (r_last == PORT_A));

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            logic                         r_valid;
            logic signed [DATA_WIDTH-1:0] r_i;
            logic signed [DATA_WIDTH-1:0] r_q;
            logic                         r_drop;
            logic [7:0]                   r_cnt;

            assign w_ready[p]    = enable & (~r_valid | w_grant[p]);
            assign w_valid[p]    = r_valid;
            assign w_buf_i[p]    = r_i;
            assign w_buf_q[p]    = r_q;
            assign w_drop[p]     = r_drop;
            assign w_drop_cnt[p] = r_cnt;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_valid <= 1'b0;
                    r_i     <= '0;
                    r_q     <= '0;
                    r_drop  <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    if (w_stb[p] & w_ready[p]) begin
                        r_valid <= 1'b1;
                        r_i     <= w_in_i[p];
                        r_q     <= w_in_q[p];
                    end else if (enable & w_grant[p]) begin
                        r_valid <= 1'b0;
                    end
                    if (w_stb[p] & ~w_ready[p]) begin
                        r_drop <= 1'b1;
                        if (r_cnt != 8'hFF) begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
            end
        end
    endgenerate

    assign w_est_i = w_grant[1] ? w_buf_i[1] : w_buf_i[0];
    assign w_est_q = w_grant[1] ? w_buf_q[1] : w_buf_q[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last  <= PORT_B;
            r_tag_v <= '0;
            for (int i = 0; i < c_EST_LATENCY; i++) begin
                r_tag_p[i] <= PORT_A;
            end
        end else if (enable) begin
            if (|w_grant) begin
                r_last <= w_grant[1] ? PORT_B : PORT_A;
            end
            r_tag_v    <= {r_tag_v[c_EST_LATENCY-2:0], |w_grant};
            r_tag_p[0] <= w_grant[1] ? PORT_B : PORT_A;
            for (int i = 1; i < c_EST_LATENCY; i++) begin
                r_tag_p[i] <= r_tag_p[i-1];
            end
        end
    end

    complex_to_mag #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_est (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .input_i      (w_est_i),
        .input_q      (w_est_q),
        .input_strobe (|w_grant),
        .mag          (w_mag),
        .mag_stb      (w_est_stb)
    );

    assign a_ready    = w_ready[0];
    assign b_ready    = w_ready[1];
    assign a_mag      = w_mag;
    assign b_mag      = w_mag;
    assign a_mag_stb  = enable & w_est_stb & r_tag_v[c_EST_LATENCY-1]
                        & (r_tag_p[c_EST_LATENCY-1] == PORT_A);
    assign b_mag_stb  = enable & w_est_stb & r_tag_v[c_EST_LATENCY-1]
                        & (r_tag_p[c_EST_LATENCY-1] == PORT_B);
    assign a_drop     = w_drop[0];
    assign b_drop     = w_drop[1];
    assign a_drop_cnt = w_drop_cnt[0];
    assign b_drop_cnt = w_drop_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_mag_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mag_arbiter
// Brief    : Self-checking bench for mag_arbiter against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_mag_arbiter;

    localparam int W = 16;

    logic                clock = 1'b0;
    logic                reset, enable, a_stb, b_stb;
    logic signed [W-1:0] a_i, a_q, b_i, b_q;
    logic                a_ready, b_ready, a_mag_stb, b_mag_stb, a_drop, b_drop;
    logic [W-1:0]        a_mag, b_mag;
    logic [7:0]          a_drop_cnt, b_drop_cnt;

    always #5 clock = ~clock;

    mag_arbiter #(.DATA_WIDTH(W)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .a_i(a_i), .a_q(a_q), .a_stb(a_stb), .a_ready(a_ready),
        .b_i(b_i), .b_q(b_q), .b_stb(b_stb), .b_ready(b_ready),
        .a_mag(a_mag), .b_mag(b_mag), .a_mag_stb(a_mag_stb), .b_mag_stb(b_mag_stb),
        .a_drop(a_drop), .b_drop(b_drop), .a_drop_cnt(a_drop_cnt), .b_drop_cnt(b_drop_cnt)
    );

    // Reference model: per-port pending sample, last winner, and results in flight
    // each carrying the number of enabled cycles it has spent in the estimator.
    typedef struct { int port; logic [W-1:0] mag; int age; } flight_t;
    flight_t fl[$];
    bit      mv[2];
    int      mi[2], mq[2], mcnt[2], n_acc[2], n_out[2];
    bit      mdrop[2];
    int      mlast, g;
    int      cyc, obs_cyc, n_checks, n_fail;

    logic         exp_a_stb, exp_b_stb, exp_a_ready, exp_b_ready, exp_a_drop, exp_b_drop;
    logic [W-1:0] exp_mag;
    logic [7:0]   exp_a_cnt, exp_b_cnt;
    logic         obs_a_stb, obs_b_stb, obs_a_ready, obs_b_ready, obs_a_drop, obs_b_drop;
    logic [W-1:0] obs_a_mag, obs_b_mag;
    logic [7:0]   obs_a_cnt, obs_b_cnt;

    function automatic logic [W-1:0] ref_mag(input int i, input int q);
        int ai, aq, mx, mn;
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        mx = (ai > aq) ? ai : aq;
        mn = (ai > aq) ? aq : ai;
        return W'((mx + mn / 4) % (1 << W));
    endfunction

    task automatic set_in(input bit as, input int ai, input int aq,
                          input bit bs, input int bi, input int bq);
        a_stb = as; a_i = W'(ai); a_q = W'(aq);
        b_stb = bs; b_i = W'(bi); b_q = W'(bq);
    endtask

    task automatic step();
        bit s[2], r[2];
        int di[2], dq[2];
        flight_t t;
        @(negedge clock);
        exp_a_stb = 1'b0; exp_b_stb = 1'b0; exp_mag = '0;
        if (enable && fl.size() > 0 && fl[0].age == 3) begin
            if (fl[0].port == 0) exp_a_stb = 1'b1; else exp_b_stb = 1'b1;
            exp_mag = fl[0].mag;
        end
        if (mv[0] && mv[1]) g = (mlast == 1) ? 0 : 1;
        else if (mv[0])     g = 0;
        else if (mv[1])     g = 1;
        else                g = -1;
        exp_a_ready = enable && (!mv[0] || g == 0);
        exp_b_ready = enable && (!mv[1] || g == 1);
        exp_a_drop = mdrop[0]; exp_b_drop = mdrop[1];
        exp_a_cnt = 8'(mcnt[0]); exp_b_cnt = 8'(mcnt[1]);
        obs_a_stb = a_mag_stb; obs_b_stb = b_mag_stb;
        obs_a_ready = a_ready; obs_b_ready = b_ready;
        obs_a_mag = a_mag; obs_b_mag = b_mag;
        obs_a_drop = a_drop; obs_b_drop = b_drop;
        obs_a_cnt = a_drop_cnt; obs_b_cnt = b_drop_cnt;
        obs_cyc = cyc;
        if (a_mag_stb) n_out[0]++;
        if (b_mag_stb) n_out[1]++;
        @(posedge clock);
        s[0] = a_stb; s[1] = b_stb; r[0] = exp_a_ready; r[1] = exp_b_ready;
        di[0] = a_i; di[1] = b_i; dq[0] = a_q; dq[1] = b_q;
        if (reset) begin
            mv[0] = 0; mv[1] = 0; mdrop[0] = 0; mdrop[1] = 0;
            mcnt[0] = 0; mcnt[1] = 0; mlast = 1; fl.delete();
        end else begin
            if (enable) begin
                if (fl.size() > 0 && fl[0].age == 3) void'(fl.pop_front());
                for (int k = 0; k < fl.size(); k++) fl[k].age = fl[k].age + 1;
                if (g >= 0) begin
                    t.port = g; t.mag = ref_mag(mi[g], mq[g]); t.age = 1;
                    fl.push_back(t);
                    mlast = g;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (s[p] && !r[p]) begin
                    mdrop[p] = 1;
                    if (mcnt[p] < 255) mcnt[p]++;
                end else if (s[p]) begin
                    mv[p] = 1; mi[p] = di[p]; mq[p] = dq[p]; n_acc[p]++;
                end else if (enable && g == p) begin
                    mv[p] = 0;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; set_in(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        reset = 0;
        step();
        n_checks++; if ({obs_a_mag, obs_b_mag} !== '0) begin n_fail++; $display("FAIL reset_mag got=%h/%h exp=0", obs_a_mag, obs_b_mag); end
        n_checks++; if ({obs_a_stb, obs_b_stb} !== 2'b00) begin n_fail++; $display("FAIL reset_stb got=%b%b exp=00", obs_a_stb, obs_b_stb); end
        n_checks++; if ({obs_a_drop, obs_b_drop, obs_a_cnt, obs_b_cnt} !== '0) begin n_fail++; $display("FAIL reset_drop got=%b%b %0d %0d exp=0", obs_a_drop, obs_b_drop, obs_a_cnt, obs_b_cnt); end
        n_checks++; if ({obs_a_ready, obs_b_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready got=%b%b exp=11", obs_a_ready, obs_b_ready); end
    endtask

    task automatic test_single();
        int t0; bit seen;
        seen = 0;
        t0 = cyc; set_in(1, 3, -4, 0, 0, 0); step(); set_in(0, 0, 0, 0, 0, 0);
        repeat (7) begin
            step();
            n_checks++; if (obs_b_stb !== 1'b0) begin n_fail++; $display("FAIL single_b_stb cyc=%0d got=%b exp=0", obs_cyc, obs_b_stb); end
            if (obs_a_stb === 1'b1) begin
                seen = 1;
                n_checks++; if (obs_cyc - t0 != 4) begin n_fail++; $display("FAIL single_latency got=%0d exp=4", obs_cyc - t0); end
                n_checks++; if (obs_a_mag !== 16'd4) begin n_fail++; $display("FAIL single_mag got=%0d exp=4", obs_a_mag); end
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL single_seen got=0 exp=1"); end
    endtask

    task automatic test_tie();
        int t0; int sa, sb;
        sa = 0; sb = 0;
        reset = 1; step(); reset = 0; step();
        t0 = cyc; set_in(1, 3, -4, 1, -100, 40); step(); set_in(0, 0, 0, 0, 0, 0);
        repeat (8) begin
            step();
            if (obs_a_stb === 1'b1) begin
                sa++;
                n_checks++; if (obs_cyc - t0 != 4 || obs_a_mag !== 16'd4) begin n_fail++; $display("FAIL tie_a got=+%0d/%0d exp=+4/4", obs_cyc - t0, obs_a_mag); end
            end
            if (obs_b_stb === 1'b1) begin
                sb++;
                n_checks++; if (obs_cyc - t0 != 5 || obs_b_mag !== 16'd110) begin n_fail++; $display("FAIL tie_b got=+%0d/%0d exp=+5/110", obs_cyc - t0, obs_b_mag); end
            end
        end
        n_checks++; if (sa != 1 || sb != 1) begin n_fail++; $display("FAIL tie_count got=%0d/%0d exp=1/1", sa, sb); end
    endtask

    task automatic test_full_rate();
        n_acc[0] = 0; n_acc[1] = 0; n_out[0] = 0; n_out[1] = 0;
        for (int n = 0; n < 27; n++) begin
            if (n < 20) set_in(1, int'($urandom) % 30000, int'($urandom) % 30000, 1, int'($urandom) % 30000, int'($urandom) % 30000);
            else        set_in(0, 0, 0, 0, 0, 0);
            step();
            n_checks++; if ({obs_a_ready, obs_b_ready, obs_a_stb, obs_b_stb} !== {exp_a_ready, exp_b_ready, exp_a_stb, exp_b_stb}) begin n_fail++; $display("FAIL full_ctl cyc=%0d got=%b%b%b%b exp=%b%b%b%b", obs_cyc, obs_a_ready, obs_b_ready, obs_a_stb, obs_b_stb, exp_a_ready, exp_b_ready, exp_a_stb, exp_b_stb); end
            if (exp_a_stb || exp_b_stb) begin n_checks++; if ((exp_a_stb ? obs_a_mag : obs_b_mag) !== exp_mag) begin n_fail++; $display("FAIL full_mag cyc=%0d got=%0d exp=%0d", obs_cyc, exp_a_stb ? obs_a_mag : obs_b_mag, exp_mag); end end
            n_checks++; if ({obs_a_drop, obs_b_drop, obs_a_cnt, obs_b_cnt} !== {exp_a_drop, exp_b_drop, exp_a_cnt, exp_b_cnt}) begin n_fail++; $display("FAIL full_drop cyc=%0d got=%0d/%0d exp=%0d/%0d", obs_cyc, obs_a_cnt, obs_b_cnt, exp_a_cnt, exp_b_cnt); end
        end
        n_checks++; if (n_out[0] != n_acc[0] || n_out[1] != n_acc[1]) begin n_fail++; $display("FAIL full_lost got=%0d/%0d exp=%0d/%0d", n_out[0], n_out[1], n_acc[0], n_acc[1]); end
    endtask

    task automatic test_corner();
        int want[2]; int got[2]; bit seen[2];
        want[0] = 32768; want[1] = 125;
        for (int c = 0; c < 2; c++) begin
            seen[c] = 0; got[c] = 0;
            if (c == 0) set_in(1, -32768, 0, 0, 0, 0); else set_in(1, 100, 100, 0, 0, 0);
            step(); set_in(0, 0, 0, 0, 0, 0);
            repeat (6) begin
                step();
                if (obs_a_stb === 1'b1) begin seen[c] = 1; got[c] = obs_a_mag; end
            end
            n_checks++; if (!seen[c] || got[c] != want[c]) begin n_fail++; $display("FAIL corner_mag%0d got=%0d seen=%0d exp=%0d", c, got[c], seen[c], want[c]); end
        end
    endtask

    task automatic test_enable_gap();
        int c0, first, total;
        first = -1; total = 0;
        set_in(1, 30, 40, 0, 0, 0); step();
        set_in(0, 0, 0, 1, -7, 24); step();
        set_in(0, 0, 0, 0, 0, 0); step();
        c0 = a_drop_cnt;
        enable = 0; set_in(1, 5, 5, 0, 0, 0);
        repeat (5) begin
            step();
            n_checks++; if ({obs_a_stb, obs_b_stb} !== 2'b00) begin n_fail++; $display("FAIL gap_stb cyc=%0d got=%b%b exp=00", obs_cyc, obs_a_stb, obs_b_stb); end
        end
        enable = 1; set_in(0, 0, 0, 0, 0, 0);
        repeat (6) begin
            step();
            n_checks++; if ({obs_a_stb, obs_b_stb, obs_a_ready, obs_b_ready} !== {exp_a_stb, exp_b_stb, exp_a_ready, exp_b_ready}) begin n_fail++; $display("FAIL gap_ctl cyc=%0d got=%b%b%b%b exp=%b%b%b%b", obs_cyc, obs_a_stb, obs_b_stb, obs_a_ready, obs_b_ready, exp_a_stb, exp_b_stb, exp_a_ready, exp_b_ready); end
            if (exp_a_stb || exp_b_stb) begin n_checks++; if ((exp_a_stb ? obs_a_mag : obs_b_mag) !== exp_mag) begin n_fail++; $display("FAIL gap_mag cyc=%0d got=%0d exp=%0d", obs_cyc, exp_a_stb ? obs_a_mag : obs_b_mag, exp_mag); end end
            if (obs_a_stb === 1'b1 || obs_b_stb === 1'b1) begin
                total++;
                if (first < 0) first = obs_b_stb ? 1 : 0;
            end
        end
        n_checks++; if (total != 2 || first != 0) begin n_fail++; $display("FAIL gap_order got=%0d first=%0d exp=2 first=0", total, first); end
        n_checks++; if (int'(a_drop_cnt) - c0 != 5) begin n_fail++; $display("FAIL gap_drops got=%0d exp=5", int'(a_drop_cnt) - c0); end
    endtask

    task automatic test_reset_mid();
        int first;
        first = -1;
        set_in(1, 3, -4, 1, 9, 9); step();
        set_in(0, 0, 0, 0, 0, 0); reset = 1; step();
        reset = 0;
        repeat (6) begin
            step();
            n_checks++; if ({obs_a_stb, obs_b_stb} !== 2'b00) begin n_fail++; $display("FAIL rmid_stb cyc=%0d got=%b%b exp=00", obs_cyc, obs_a_stb, obs_b_stb); end
        end
        n_checks++; if ({obs_a_drop, obs_b_drop, obs_a_cnt, obs_b_cnt} !== '0) begin n_fail++; $display("FAIL rmid_drop got=%b%b %0d %0d exp=0", obs_a_drop, obs_b_drop, obs_a_cnt, obs_b_cnt); end
        set_in(1, 1, 1, 1, 2, 2); step(); set_in(0, 0, 0, 0, 0, 0);
        repeat (7) begin
            step();
            if (first < 0 && (obs_a_stb === 1'b1 || obs_b_stb === 1'b1)) first = obs_b_stb ? 1 : 0;
        end
        n_checks++; if (first != 0) begin n_fail++; $display("FAIL rmid_tie got=%0d exp=0", first); end
    endtask

    task automatic test_random();
        int sel;
        for (int n = 0; n < 1500; n++) begin
            reset  = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 99) < 85);
            sel = $urandom_range(0, 3);
            set_in($urandom_range(0, 9) < 6, (sel == 0) ? -32768 : int'($urandom),
                   (sel == 1) ? 32767 : int'($urandom),
                   $urandom_range(0, 9) < 6, int'($urandom), (sel == 2) ? -32768 : int'($urandom));
            step();
            n_checks++; if ({obs_a_ready, obs_b_ready, obs_a_stb, obs_b_stb} !== {exp_a_ready, exp_b_ready, exp_a_stb, exp_b_stb}) begin n_fail++; $display("FAIL rand_ctl cyc=%0d got=%b%b%b%b exp=%b%b%b%b", obs_cyc, obs_a_ready, obs_b_ready, obs_a_stb, obs_b_stb, exp_a_ready, exp_b_ready, exp_a_stb, exp_b_stb); end
            if (exp_a_stb || exp_b_stb) begin n_checks++; if ((exp_a_stb ? obs_a_mag : obs_b_mag) !== exp_mag) begin n_fail++; $display("FAIL rand_mag cyc=%0d got=%0d exp=%0d", obs_cyc, exp_a_stb ? obs_a_mag : obs_b_mag, exp_mag); end end
            n_checks++; if ({obs_a_drop, obs_b_drop, obs_a_cnt, obs_b_cnt} !== {exp_a_drop, exp_b_drop, exp_a_cnt, exp_b_cnt}) begin n_fail++; $display("FAIL rand_drop cyc=%0d got=%b%b %0d/%0d exp=%b%b %0d/%0d", obs_cyc, obs_a_drop, obs_b_drop, obs_a_cnt, obs_b_cnt, exp_a_drop, exp_b_drop, exp_a_cnt, exp_b_cnt); end
        end
        reset = 0; enable = 1; set_in(0, 0, 0, 0, 0, 0);
        repeat (6) step();
    endtask

    task automatic test_saturate();
        reset = 1; step(); reset = 0;
        enable = 0; set_in(1, 0, 0, 0, 0, 0);
        repeat (300) step();
        enable = 1; set_in(0, 0, 0, 0, 0, 0); step();
        n_checks++; if (obs_a_cnt !== 8'd255 || obs_a_drop !== 1'b1) begin n_fail++; $display("FAIL sat_cnt got=%0d/%b exp=255/1", obs_a_cnt, obs_a_drop); end
        n_checks++; if (obs_b_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_other got=%0d exp=0", obs_b_cnt); end
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0; mlast = 1; g = -1;
        mv[0] = 0; mv[1] = 0; mdrop[0] = 0; mdrop[1] = 0; mcnt[0] = 0; mcnt[1] = 0;
        mi[0] = 0; mi[1] = 0; mq[0] = 0; mq[1] = 0;
        n_acc[0] = 0; n_acc[1] = 0; n_out[0] = 0; n_out[1] = 0;
        test_reset();
        test_single();
        test_tie();
        test_full_rate();
        test_corner();
        test_enable_gap();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
